// File: rtl/arb2_1_if.sv
// arb2_1_if: request/grant and output handshake bundle for the two-source
// arbiter. The slave modport is the arbiter's view; master is the view of the
// surrounding sources and consumer.
interface arb2_1_if #(
  parameter int WIDTH = 16
);
  logic             ReqA;
  logic [WIDTH-1:0] DataA;
  logic             ReqB;
  logic [WIDTH-1:0] DataB;
  logic             GntA;
  logic             GntB;
  logic             Sel;
  logic             OutValid;
  logic [WIDTH-1:0] OutData;
  logic             OutReady;

  modport slave (
    input  ReqA, DataA, ReqB, DataB, OutReady,
    output GntA, GntB, Sel, OutValid, OutData
  );

  modport master (
    output ReqA, DataA, ReqB, DataB, OutReady,
    input  GntA, GntB, Sel, OutValid, OutData
  );
endinterface

// File: rtl/arb2_1.sv
// arb2_1: two-source arbiter feeding a 2-entry output FIFO.
// Configuration macro: ARB2_RR_EN. When defined, arbitration is round-robin
// (a priority bit flips after each grant); when undefined, A has fixed
// priority and no priority register exists.
// Grants are combinational from requests, OutReady and state only; data words
// reach the outputs solely through the FIFO registers.
module arb2_1 #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  arb2_1_if.slave  bus
);

  // FIFO state
  logic [1:0]       count_q,  count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem0_q,   mem0_d;
  logic [WIDTH-1:0] mem1_q,   mem1_d;

  // Arbitration and handshake terms
  logic             pri_s;
  logic             pop_s;
  logic             accept_s;
  logic             gnt_a_s;
  logic             gnt_b_s;
  logic             push_s;
  logic [WIDTH-1:0] wdata_s;

`ifdef ARB2_RR_EN
  logic pri_q, pri_d;

  // Priority flips toward the source that did not win the last grant
  always_comb begin
    pri_d = pri_q;
    if (gnt_a_s) begin
      pri_d = 1'b1;
    end else if (gnt_b_s) begin
      pri_d = 1'b0;
    end else begin
      pri_d = pri_q;
    end
  end

  // Priority register
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
    end
  end

  assign pri_s = pri_q;
`else
  // Fixed priority: A always preferred
  assign pri_s = 1'b0;
`endif

  // Pop when the head is offered and taken; accept when a slot is free or one frees now
  always_comb begin
    pop_s    = (count_q != 2'd0) && bus.OutReady;
    accept_s = (count_q != 2'd2) || pop_s;
  end

  // Grant selection; grants are suppressed while reset is asserted
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (rst) begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end else if (accept_s) begin
      case ({bus.ReqA, bus.ReqB})
        2'b10: gnt_a_s = 1'b1;
        2'b01: gnt_b_s = 1'b1;
        2'b11: begin
          if (pri_s) begin
            gnt_b_s = 1'b1;
          end else begin
            gnt_a_s = 1'b1;
          end
        end
        default: begin
          gnt_a_s = 1'b0;
          gnt_b_s = 1'b0;
        end
      endcase
    end else begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end
  end

  // Write word selection follows the mux select
  always_comb begin
    push_s = gnt_a_s | gnt_b_s;
    if (gnt_b_s) begin
      wdata_s = bus.DataB;
    end else begin
      wdata_s = bus.DataA;
    end
  end

  // FIFO next state: storage, pointers and occupancy
  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      if (wr_ptr_q) begin
        mem1_d = wdata_s;
      end else begin
        mem0_d = wdata_s;
      end
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Output drive: grants/select from arbitration, head word from the FIFO registers
  always_comb begin
    bus.GntA     = gnt_a_s;
    bus.GntB     = gnt_b_s;
    bus.Sel      = gnt_b_s;
    bus.OutValid = (count_q != 2'd0);
    if (rd_ptr_q) begin
      bus.OutData = mem1_q;
    end else begin
      bus.OutData = mem0_q;
    end
  end

endmodule

// File: tb/tb_arb2_1.sv
// tb_arb2_1: directed bench for arb2_1. Inputs change 1 time unit after the
// rising edge; combinational grants are checked on the falling edge and
// registered outputs just after the rising edge. Expectations depend on
// ARB2_RR_EN only where arbitration between simultaneous requests differs.
module tb_arb2_1;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  arb2_1_if #(.WIDTH(16)) bus ();

  arb2_1 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_gnt(input string tag, input logic ga, input logic gb);
    chk({tag, "_gntA"}, {31'd0, bus.GntA}, {31'd0, ga});
    chk({tag, "_gntB"}, {31'd0, bus.GntB}, {31'd0, gb});
    chk({tag, "_sel"},  {31'd0, bus.Sel},  {31'd0, gb});
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d);
    chk({tag, "_valid"}, {31'd0, bus.OutValid}, {31'd0, v});
    chk({tag, "_data"},  {16'd0, bus.OutData},  {16'd0, d});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset with both sources requesting
    rst = 1'b1;
    bus.ReqA = 1'b1;
    bus.ReqB = 1'b1;
    bus.DataA = 16'hAAAA;
    bus.DataB = 16'hBBBB;
    bus.OutReady = 1'b1;
    mid();  chk_gnt("rst_c0", 1'b0, 1'b0);
    tick();
    mid();  chk_gnt("rst_c1", 1'b0, 1'b0);
    tick();
    chk_out("rst_out", 1'b0, 16'h0000);
    rst = 1'b0;

    // Both requesting, consumer always ready
    mid();  chk_gnt("alt_c0", 1'b1, 1'b0);
    tick(); chk_out("alt_o1", 1'b1, 16'hAAAA);
`ifdef ARB2_RR_EN
    mid();  chk_gnt("alt_c1", 1'b0, 1'b1);
    tick(); chk_out("alt_o2", 1'b1, 16'hBBBB);
    mid();  chk_gnt("alt_c2", 1'b1, 1'b0);
    tick(); chk_out("alt_o3", 1'b1, 16'hAAAA);
    mid();  chk_gnt("alt_c3", 1'b0, 1'b1);
    tick(); chk_out("alt_o4", 1'b1, 16'hBBBB);
`else
    mid();  chk_gnt("fix_c1", 1'b1, 1'b0);
    tick(); chk_out("fix_o2", 1'b1, 16'hAAAA);
    mid();  chk_gnt("fix_c2", 1'b1, 1'b0);
    tick(); chk_out("fix_o3", 1'b1, 16'hAAAA);
    mid();  chk_gnt("fix_c3", 1'b1, 1'b0);
    tick(); chk_out("fix_o4", 1'b1, 16'hAAAA);
`endif

    // Drain the single remaining word
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b0;
    mid();  chk_gnt("drain", 1'b0, 1'b0);
    tick(); chk("drain_valid", {31'd0, bus.OutValid}, 32'd0);

    // Fill under backpressure, then release
    bus.OutReady = 1'b0;
    bus.ReqA = 1'b1;
    bus.DataA = 16'h0001;
    mid();  chk_gnt("bp_w1", 1'b1, 1'b0);
    tick(); chk_out("bp_h1", 1'b1, 16'h0001);
    bus.DataA = 16'h0002;
    mid();  chk_gnt("bp_w2", 1'b1, 1'b0);
    tick();
    bus.DataA = 16'h0003;
    mid();  chk_gnt("bp_full", 1'b0, 1'b0);
    tick(); chk_out("bp_hold", 1'b1, 16'h0001);
    mid();  chk_gnt("bp_full2", 1'b0, 1'b0);
    tick();
    bus.OutReady = 1'b1;
    mid();  chk_gnt("bp_pushpop", 1'b1, 1'b0);
    tick(); chk_out("bp_h2", 1'b1, 16'h0002);
    bus.ReqA = 1'b0;
    mid();  chk_gnt("bp_idle", 1'b0, 1'b0);
    tick(); chk_out("bp_h3", 1'b1, 16'h0003);
    tick(); chk("bp_empty", {31'd0, bus.OutValid}, 32'd0);

    // Single requester B; afterwards A must win a tie
    bus.ReqB = 1'b1;
    bus.DataB = 16'h0042;
    mid();  chk_gnt("solo_b", 1'b0, 1'b1);
    tick(); chk_out("solo_o", 1'b1, 16'h0042);
    bus.ReqA = 1'b1;
    bus.DataA = 16'h1111;
    mid();  chk_gnt("solo_pri", 1'b1, 1'b0);
    tick(); chk_out("solo_o2", 1'b1, 16'h1111);

    // Fill to two entries, then reset mid-operation
    bus.OutReady = 1'b0;
    bus.ReqB = 1'b0;
    bus.DataA = 16'h2222;
    mid();  chk_gnt("mr_fill", 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    bus.ReqB = 1'b1;
    mid();  chk_gnt("mr_rst", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b0;
    chk_out("mr_out", 1'b0, 16'h0000);
    bus.ReqA = 1'b1;
    bus.ReqB = 1'b1;
    bus.DataA = 16'h3333;
    bus.DataB = 16'h4444;
    mid();  chk_gnt("mr_pri", 1'b1, 1'b0);
    tick(); chk_out("mr_new", 1'b1, 16'h3333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
